mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 100 ++++++++++
 tb/tb_mult_div_unit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-step signed/unsigned multiply and restoring divide with HI/LO result registers
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIXUP, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, mul_n, div_n, fix;
    logic [WIDTH-1:0]   mag, a_raw, a_abs, b_abs;
    logic [WIDTH:0]     sum;
    logic [WIDTH+1:0]   diff;
    logic               sa, sb, dz, is_div, a_neg, b_neg, accept;
    assign busy   = state == MUL || state == DIV || state == FIXUP;
    assign done   = state == DONE;
    assign accept = start && (state == IDLE || state == DONE);
    assign a_neg  = !op[0] && A_in[WIDTH-1];
    assign b_neg  = !op[0] && B_in[WIDTH-1];
    assign a_abs  = a_neg ? -A_in : A_in;
    assign b_abs  = b_neg ? -B_in : B_in;
    // shift-add: conditionally add multiplicand to the upper half, then shift the whole accumulator right
    assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag} : {(WIDTH+1){1'b0}});
    assign mul_n  = {sum, acc[WIDTH-1:1]};
    // restoring divide: the upper half holds the partial remainder, the lower half shifts in quotient bits
    assign diff   = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {2'b00, mag};
    assign div_n  = diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign fix    = is_div ? {sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH],
                              (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]}
                           : ((sa ^ sb) ? -acc : acc);
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = accept ? (op[1] ? DIV : MUL) : IDLE;
            MUL, DIV:   state_n = cnt == CW'(WIDTH - 1) ? FIXUP : state;
            FIXUP:      state_n = cnt[0] ? DONE : FIXUP;
            default:    state_n = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            mag         <= '0;
            a_raw       <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            dz          <= 1'b0;
            is_div      <= 1'b0;
            div_by_zero <= 1'b0;
            HI          <= '0;
            LO          <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE, DONE: if (accept) begin
                    cnt         <= '0;
                    is_div      <= op[1];
                    sa          <= a_neg;
                    sb          <= b_neg;
                    a_raw       <= A_in;
                    dz          <= op[1] && B_in == '0;
                    div_by_zero <= 1'b0;
                    acc         <= {{WIDTH{1'b0}}, op[1] ? a_abs : b_abs};
                    mag         <= op[1] ? b_abs : a_abs;
                end
                MUL: begin
                    acc <= mul_n;
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    acc <= div_n;
                    cnt <= cnt + 1'b1;
                end
                FIXUP: if (!cnt[0]) begin
                    acc <= fix;
                    cnt <= cnt + 1'b1;
                end else begin
                    HI          <= dz ? a_raw : acc[2*WIDTH-1:WIDTH];
                    LO          <= dz ? '1 : acc[WIDTH-1:0];
                    div_by_zero <= dz;
                    cnt         <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for mult_div_unit with hand-computed HI/LO and latency
module tb_mult_div_unit;
    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] A_in = '0, B_in = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] HI, LO;
    int          n_vec = 0, n_err = 0, cyc = 0, e_cyc = 0, n_done = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .reset(reset), .start(start), .op(op), .A_in(A_in), .B_in(B_in),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // start is seen at edge E; inputs are scrambled afterwards since they must be ignored
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        start = 1'b1; op = o; A_in = a; B_in = b;
        @(posedge Clk); #1;
        start = 1'b0; e_cyc = cyc;
        A_in = $urandom; B_in = $urandom; op = 2'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 60) begin
            @(posedge Clk); #1;
            n++;
        end
        check({tag, "_lat"}, 64'(cyc - e_cyc), 64'd34);
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi_e, input logic [31:0] lo_e);
        start_op(o, a, b);
        wait_done(tag);
        check({tag, "_hi"}, 64'(HI), 64'(hi_e));
        check({tag, "_lo"}, 64'(LO), 64'(lo_e));
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_hi", 64'(HI), 64'd0);
        check("rst_lo", 64'(LO), 64'd0);
        @(negedge Clk) reset = 1'b0;

        start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("mulu_busy_e0", 64'(busy), 64'd1);
        repeat (32) @(posedge Clk);
        #1;
        check("mulu_busy_e32", 64'(busy), 64'd1);
        check("mulu_nodone_e32", 64'(done), 64'd0);
        check("mulu_hi_hold", 64'(HI), 64'd0);
        wait_done("mulu_ff");
        check("mulu_busy_done", 64'(busy), 64'd0);
        check("mulu_ff_hi", 64'(HI), 64'hFFFFFFFE);
        check("mulu_ff_lo", 64'(LO), 64'h00000001);
        @(posedge Clk); #1;
        check("mulu_done_pulse", 64'(done), 64'd0);
        check("mulu_idle_busy", 64'(busy), 64'd0);

        run("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run("mult_min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        run("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        check("div_ovf_dbz", 64'(div_by_zero), 64'd0);
        run("divu_zero", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
        check("divu_zero_dbz", 64'(div_by_zero), 64'd1);

        start_op(2'b11, 32'd9, 32'd3);
        check("dbz_clear", 64'(div_by_zero), 64'd0);
        wait_done("divu_9_3");
        check("divu_9_3_hi", 64'(HI), 64'd0);
        check("divu_9_3_lo", 64'(LO), 64'd3);

        start_op(2'b01, 32'h12345678, 32'h10);
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        start = 1'b1; op = 2'b10; A_in = 32'hDEADBEEF; B_in = 32'h5;
        @(posedge Clk); #1;
        start = 1'b0;
        check("mid_busy", 64'(busy), 64'd1);
        check("mid_hi_hold", 64'(HI), 64'd0);
        check("mid_lo_hold", 64'(LO), 64'd3);
        repeat (3) begin
            @(negedge Clk) A_in = ~A_in;
        end
        wait_done("ignore");
        check("ignore_hi", 64'(HI), 64'h1);
        check("ignore_lo", 64'(LO), 64'h23456780);

        run("b2b_2x3", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6);
        @(posedge Clk); #1;
        run("mulu_4x4", 2'b01, 32'd4, 32'd4, 32'd0, 32'd16);

        start_op(2'b00, 32'd5, 32'd6);
        repeat (9) @(posedge Clk);
        @(negedge Clk) reset = 1'b1;
        @(posedge Clk); #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(HI), 64'd0);
        check("abort_lo", 64'(LO), 64'd0);
        @(negedge Clk) reset = 1'b0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        run("after_abort", 2'b00, 32'hFFFFFFFA, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFD6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
